flag_stack: RTL and testbench
=============================

FLAG_STACK -- requirements
Module: flag_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of saved flag entries (power of two, 2..16).
REQ-002 SHALL have parameter FW, default 4, meaning saved flag vector width, bit order {V,C,N,Z} (Z = bit 0).
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port push  input  1  save flags_in on interrupt entry.
REQ-006 SHALL have port pop  input  1  restore the top entry on interrupt return.
REQ-007 SHALL have port flags_in  input  FW  live zero/negative/carry/overflow flags from the flag register.
REQ-008 SHALL have port flags_out  output  FW  restored flag vector, for loading back into the flag register.
REQ-009 SHALL have port restore_valid  output  1  one-cycle pulse: flags_out holds valid restored flags.
REQ-010 SHALL have port depth  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-011 SHALL have ports full and empty  output  1 each  depth==DEPTH and depth==0 respectively.
REQ-012 SHALL have ports err_overflow and err_underflow  output  1 each  sticky error flags.
REQ-013 SHALL have port err_clr  input  1  clears both sticky error flags.

Function
REQ-014 Push only, not full: SHALL write flags_in at index depth, depth+1 next cycle.
REQ-015 Push only, full: SHALL discard the write, leave depth and entries unchanged, set err_overflow.
REQ-016 Pop only, not empty: SHALL register the top entry into flags_out, pulse restore_valid the following cycle (latency 1), depth-1.
REQ-017 Pop only, empty: SHALL leave depth and flags_out unchanged, no restore_valid, set err_underflow.
REQ-018 Push and pop together, not empty: SHALL output old top on flags_out with restore_valid, replace top with flags_in, depth unchanged, no error even when full.
REQ-019 Push and pop together, empty: SHALL perform the push only (depth 0->1), no restore_valid, set err_underflow.
REQ-020 restore_valid SHALL be high for exactly one cycle per successful pop; flags_out SHALL hold its value until the next successful pop.
REQ-021 full, empty, depth SHALL be registered-state-derived, never combinational from push/pop.
REQ-022 err_clr SHALL clear errors next cycle; an error event in the same cycle as err_clr SHALL win (flag set).
REQ-023 Index arithmetic SHALL never wrap: depth stays within 0..DEPTH under all input sequences.

Reset
REQ-024 Asserted reset (low) SHALL immediately force depth=0, empty=1, full=0, flags_out=0, restore_valid=0, err_overflow=0, err_underflow=0.
REQ-025 Stored entries SHALL NOT require reset; they are unobservable while empty.
REQ-026 Reset mid-sequence SHALL abandon all saved contexts; a pop in the first cycle after release SHALL be an underflow.

Structure
REQ-027 Flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3) and FW SHALL live in the shared CPU package, used also by the flag register and the ALU.
REQ-028 No sub-module SHALL be used; storage is a local register array with a depth counter.

Verification
REQ-029 Reset, push 4'b0001,4'b0010,4'b0100,4'b1000 -> depth=4, full=1, no errors.
REQ-030 From full, push 4'b1111 then four pops -> err_overflow=1; flags_out sequence 1000,0100,0010,0001 each with one restore_valid pulse; empty=1 at end.
REQ-031 From empty, pop -> err_underflow=1, restore_valid never asserts, flags_out unchanged; err_clr -> err_underflow=0 next cycle.
REQ-032 depth=2 (top 4'b0101), push+pop with flags_in=4'b1010 -> flags_out=0101, restore_valid pulse, depth=2; subsequent pop -> flags_out=1010.
REQ-033 depth=3, assert reset low for a partial cycle -> outputs at reset values immediately; after release, pop -> err_underflow=1.

Source files
------------

// File: rtl/flag_stack_pkg.sv
// rtl/flag_stack_pkg.sv - shared CPU flag definitions and flag stack op decode
package flag_stack_pkg;

   localparam int FW     = 4;
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_SWAP = 2'b11
   } stack_op_e;

   function automatic stack_op_e decode_op(input logic push, input logic pop);
      return stack_op_e'({pop, push});
   endfunction

endpackage

// File: rtl/flag_stack.sv
// rtl/flag_stack.sv - interrupt flag save/restore stack with sticky error flags
module flag_stack
   import flag_stack_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int FW    = flag_stack_pkg::FW
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [FW-1:0]              flags_in,
   input  logic                       err_clr,
   output logic [FW-1:0]              flags_out,
   output logic                       restore_valid,
   output logic [$clog2(DEPTH):0]     depth,
   output logic                       full,
   output logic                       empty,
   output logic                       err_overflow,
   output logic                       err_underflow
);

   localparam int DW = $clog2(DEPTH) + 1;
   localparam int AW = $clog2(DEPTH);
   localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

   logic [FW-1:0] mem [DEPTH];
   stack_op_e     op;
   logic [AW-1:0] top_idx;
   logic [AW-1:0] wr_idx;
   logic          wr_en;
   logic          pop_ok;
   logic          ovf_evt;
   logic          unf_evt;

   assign op      = decode_op(push, pop);
   assign empty   = (depth == '0);
   assign full    = (depth == DEPTH_V);
   assign top_idx = AW'(depth - DW'(1));

   assign pop_ok  = ((op == OP_POP) || (op == OP_SWAP)) && !empty;
   assign unf_evt = ((op == OP_POP) || (op == OP_SWAP)) && empty;
   assign ovf_evt = (op == OP_PUSH) && full;

   // A swap on an empty stack degenerates to a plain push into slot 0.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = AW'(depth);
      case (op)
         OP_PUSH: wr_en = !full;
         OP_SWAP: begin
            wr_en  = 1'b1;
            wr_idx = empty ? '0 : top_idx;
         end
         default: wr_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= flags_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         depth         <= '0;
         flags_out     <= '0;
         restore_valid <= 1'b0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         restore_valid <= pop_ok;
         if (pop_ok) flags_out <= mem[top_idx];

         case (op)
            OP_PUSH: if (!full)  depth <= depth + DW'(1);
            OP_POP:  if (!empty) depth <= depth - DW'(1);
            OP_SWAP: if (empty)  depth <= DW'(1);
            default: depth <= depth;
         endcase

         // An error event in the same cycle as err_clr keeps the flag set.
         err_overflow  <= ovf_evt | (err_overflow  & ~err_clr);
         err_underflow <= unf_evt | (err_underflow & ~err_clr);
      end
   end

endmodule

// File: tb/tb_flag_stack.sv
// tb/tb_flag_stack.sv - scoreboard bench for flag_stack
module tb_flag_stack;

   localparam int DEPTH = 4;
   localparam int FW    = 4;
   localparam int DW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic [FW-1:0] flags_in = '0;
   logic          err_clr = 1'b0;
   logic [FW-1:0] flags_out;
   logic          restore_valid;
   logic [DW-1:0] depth;
   logic          full;
   logic          empty;
   logic          err_overflow;
   logic          err_underflow;

   int n_checks = 0;
   int n_pass   = 0;

   logic [FW-1:0] stk[$];
   logic [FW-1:0] sb[$];
   logic [FW-1:0] last_out = '0;
   logic          m_ovf = 1'b0;
   logic          m_unf = 1'b0;

   flag_stack #(.DEPTH(DEPTH), .FW(FW)) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .flags_in(flags_in),
      .err_clr(err_clr), .flags_out(flags_out), .restore_valid(restore_valid),
      .depth(depth), .full(full), .empty(empty),
      .err_overflow(err_overflow), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic check_state();
      check("depth", 8'(depth), 8'(stk.size()));
      check("full", 8'(full), 8'(stk.size() == DEPTH));
      check("empty", 8'(empty), 8'(stk.size() == 0));
      check("err_overflow", 8'(err_overflow), 8'(m_ovf));
      check("err_underflow", 8'(err_underflow), 8'(m_unf));
   endtask

   task automatic step(input logic p, input logic q, input logic [FW-1:0] f, input logic c);
      logic exp_rv;
      logic ovf;
      logic unf;
      @(negedge clk);
      push = p; pop = q; flags_in = f; err_clr = c;
      exp_rv = 1'b0; ovf = 1'b0; unf = 1'b0;
      if (p && q) begin
         if (stk.size() > 0) begin
            sb.push_back(stk[stk.size()-1]);
            stk[stk.size()-1] = f;
            exp_rv = 1'b1;
         end else begin
            stk.push_back(f);
            unf = 1'b1;
         end
      end else if (p) begin
         if (stk.size() < DEPTH) stk.push_back(f);
         else ovf = 1'b1;
      end else if (q) begin
         if (stk.size() > 0) begin
            sb.push_back(stk.pop_back());
            exp_rv = 1'b1;
         end else unf = 1'b1;
      end
      m_ovf = ovf | (m_ovf & ~c);
      m_unf = unf | (m_unf & ~c);
      @(posedge clk);
      #1;
      check("restore_valid", 8'(restore_valid), 8'(exp_rv));
      if (exp_rv && sb.size() > 0) begin
         last_out = sb.pop_front();
         check("flags_out", 8'(flags_out), 8'(last_out));
      end else begin
         check("flags_hold", 8'(flags_out), 8'(last_out));
      end
      check_state();
   endtask

   task automatic check_reset_outputs();
      check("rst_depth", 8'(depth), 8'd0);
      check("rst_empty", 8'(empty), 8'd1);
      check("rst_full", 8'(full), 8'd0);
      check("rst_flags_out", 8'(flags_out), 8'd0);
      check("rst_restore_valid", 8'(restore_valid), 8'd0);
      check("rst_err_overflow", 8'(err_overflow), 8'd0);
      check("rst_err_underflow", 8'(err_underflow), 8'd0);
   endtask

   // Assert reset a couple of ns after an edge and release before the next negedge.
   task automatic pulse_reset();
      @(posedge clk);
      #2;
      push = 1'b0; pop = 1'b0; err_clr = 1'b0; flags_in = '0;
      reset = 1'b0;
      #1;
      check_reset_outputs();
      stk.delete(); sb.delete();
      last_out = '0; m_ovf = 1'b0; m_unf = 1'b0;
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #1;
      check_reset_outputs();
      pulse_reset();

      // Fill with one-hot flag vectors
      step(1, 0, 4'b0001, 0);
      step(1, 0, 4'b0010, 0);
      step(1, 0, 4'b0100, 0);
      step(1, 0, 4'b1000, 0);
      check("fill_full", 8'(full), 8'd1);

      // Overflow then drain
      step(1, 0, 4'b1111, 0);
      check("ovf_set", 8'(err_overflow), 8'd1);
      step(0, 1, 4'b0000, 0);
      step(0, 1, 4'b0000, 0);
      step(0, 1, 4'b0000, 0);
      step(0, 1, 4'b0000, 0);
      check("drain_last", 8'(flags_out), 8'b0001);
      check("drain_empty", 8'(empty), 8'd1);
      step(0, 0, 4'b0000, 0);
      step(0, 0, 4'b0000, 1);

      // Underflow, clear, and error winning over clear
      step(0, 1, 4'b0000, 0);
      check("unf_set", 8'(err_underflow), 8'd1);
      step(0, 0, 4'b0000, 1);
      step(0, 1, 4'b0000, 1);
      step(0, 0, 4'b0000, 1);

      // Swap at depth 2, then pop
      step(1, 0, 4'b0011, 0);
      step(1, 0, 4'b0101, 0);
      step(1, 1, 4'b1010, 0);
      check("swap_out", 8'(flags_out), 8'b0101);
      step(0, 1, 4'b0000, 0);
      check("swap_pop", 8'(flags_out), 8'b1010);
      step(0, 1, 4'b0000, 0);

      // Swap on empty acts as push with underflow; swap at full has no error
      step(1, 1, 4'b0110, 0);
      step(1, 0, 4'b0111, 1);
      step(1, 0, 4'b1001, 0);
      step(1, 0, 4'b1011, 0);
      step(1, 1, 4'b1100, 0);
      check("swap_full_no_ovf", 8'(err_overflow), 8'd0);

      // Reset from depth 3 mid-cycle, then pop underflows immediately
      step(0, 1, 4'b0000, 0);
      pulse_reset();
      step(0, 1, 4'b0000, 0);
      check("post_reset_unf", 8'(err_underflow), 8'd1);

      for (int i = 0; i < 60; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0));
      end
      check("sb_drained", 8'(sb.size()), 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
